// File: rtl/sd_card_pkg.sv
// Shared definitions for the SD card controller and its front-end arbiter.
package sd_card_pkg;

  localparam logic [7:0] SD_OP_NOP   = 8'd0;
  localparam logic [7:0] SD_OP_READ  = 8'd1;
  localparam logic [7:0] SD_OP_WRITE = 8'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT     = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_ERROR    = 3'd4
  } sd_state_e;

  // Operation latched from the winning requester for the whole sector transfer
  typedef struct packed {
    logic        port;
    logic [7:0]  op;
    logic [31:0] addr;
  } sd_op_t;

endpackage

// File: rtl/sd_done_sync.sv
// Brings the SD-clock-domain completion strobe into i_clk and turns its rising edge into a pulse.
module sd_done_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_evt_c
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], i_async};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Bits 0/1 are the synchronizer, bit 2 is the edge-detect history
  assign o_evt_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sd_card_arbiter.sv
// Round-robin sharing of one SD card controller between two sector-level requesters.
module sd_card_arbiter
  import sd_card_pkg::*;
#(
  parameter int unsigned START_HOLD = 64,
  parameter int unsigned TIMEOUT    = 2**24,
  parameter int unsigned COOLDOWN   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_wr_nrd0,
  input  logic        i_wr_nrd1,
  input  logic [31:0] i_sector0,
  input  logic [31:0] i_sector1,
  input  logic [7:0]  i_wdata0,
  input  logic [7:0]  i_wdata1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_done0,
  output logic        o_done1,
  output logic        o_err0,
  output logic        o_err1,
  output logic [7:0]  o_rdata,
  output logic [7:0]  o_status,
  output logic [7:0]  o_sd_controlreg,
  output logic [31:0] o_sd_addr,
  output logic [7:0]  o_sd_wdata,
  input  logic [7:0]  i_sd_rdata,
  input  logic [7:0]  i_sd_status,
  input  logic        i_sd_done
);

  localparam int unsigned CNT_W  = $clog2((TIMEOUT > START_HOLD) ? TIMEOUT : START_HOLD) + 1;
  localparam int unsigned COOL_W = $clog2(COOLDOWN + 1) + 1;

  sd_state_e         state_q, state_d;
  sd_op_t            cur_q, cur_d;
  logic              last_q, last_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        status_q, status_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [COOL_W-1:0] cool_q, cool_d;
  logic              early_q, early_d;
  logic              done_evt;
  logic              win;
  logic [7:0]        win_op;

  sd_done_sync u_done_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_sd_done),
    .o_evt_c (done_evt)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    status_d = status_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    early_d  = early_q;
    cool_d   = (cool_q != '0) ? cool_q - COOL_W'(1) : '0;
    // Contention goes to the port that did not own the previous operation
    win      = (i_req0 & i_req1) ? ~last_q : i_req1;
    win_op   = (win ? i_wr_nrd1 : i_wr_nrd0) ? SD_OP_WRITE : SD_OP_READ;

    unique case (state_q)
      ST_IDLE: begin
        if ((i_req0 | i_req1) && (cool_q == '0)) begin
          cur_d.port = win;
          cur_d.op   = win_op;
          cur_d.addr = win ? i_sector1 : i_sector0;
          gnt_d      = win ? 2'b10 : 2'b01;
          ctrl_d     = win_op;
          cnt_d      = '0;
          early_d    = 1'b0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (done_evt) begin
          early_d = 1'b1;
        end
        if (cnt_q == CNT_W'(START_HOLD - 1)) begin
          ctrl_d = SD_OP_NOP;
          cnt_d  = '0;
          // A completion seen while the opcode was still held finishes at release
          if (early_q | done_evt) begin
            status_d = i_sd_status;
            done_d   = gnt_q;
            state_d  = ST_COMPLETE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          ctrl_d = cur_q.op;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done_evt) begin
          status_d = i_sd_status;
          done_d   = gnt_q;
          state_d  = ST_COMPLETE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          state_d = ST_ERROR;
        end
      end
      ST_COMPLETE, ST_ERROR: begin
        gnt_d   = '0;
        last_d  = cur_q.port;
        cool_d  = COOL_W'(COOLDOWN);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      status_q <= '0;
      ctrl_q   <= SD_OP_NOP;
      cnt_q    <= '0;
      cool_q   <= '0;
      early_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      status_q <= status_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      cool_q   <= cool_d;
      early_q  <= early_d;
    end
  end

  assign o_gnt0          = gnt_q[0];
  assign o_gnt1          = gnt_q[1];
  assign o_done0         = done_q[0];
  assign o_done1         = done_q[1];
  assign o_err0          = err_q[0];
  assign o_err1          = err_q[1];
  assign o_status        = status_q;
  assign o_sd_controlreg = ctrl_q;
  assign o_sd_addr       = cur_q.addr;
  assign o_sd_wdata      = gnt_q[0] ? i_wdata0 : (gnt_q[1] ? i_wdata1 : 8'h00);
  assign o_rdata         = (gnt_q != 2'b00) ? i_sd_rdata : 8'h00;

endmodule

// File: tb/tb_sd_card_arbiter.sv
// Randomized scoreboard bench for sd_card_arbiter with an emulated SD controller.
`timescale 1ns/1ps
module tb_sd_card_arbiter;

  localparam int unsigned START_HOLD = 64;
  localparam int unsigned TIMEOUT    = 1000;
  localparam int unsigned COOLDOWN   = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req0, i_req1, i_wr_nrd0, i_wr_nrd1;
  logic [31:0] i_sector0, i_sector1;
  logic [7:0]  i_wdata0, i_wdata1;
  logic        o_gnt0, o_gnt1, o_done0, o_done1, o_err0, o_err1;
  logic [7:0]  o_rdata, o_status, o_sd_controlreg, o_sd_wdata;
  logic [31:0] o_sd_addr;
  logic [7:0]  i_sd_rdata, i_sd_status;
  logic        i_sd_done;

  sd_card_arbiter #(
    .START_HOLD (START_HOLD),
    .TIMEOUT    (TIMEOUT),
    .COOLDOWN   (COOLDOWN)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req0          (i_req0),
    .i_req1          (i_req1),
    .i_wr_nrd0       (i_wr_nrd0),
    .i_wr_nrd1       (i_wr_nrd1),
    .i_sector0       (i_sector0),
    .i_sector1       (i_sector1),
    .i_wdata0        (i_wdata0),
    .i_wdata1        (i_wdata1),
    .o_gnt0          (o_gnt0),
    .o_gnt1          (o_gnt1),
    .o_done0         (o_done0),
    .o_done1         (o_done1),
    .o_err0          (o_err0),
    .o_err1          (o_err1),
    .o_rdata         (o_rdata),
    .o_status        (o_status),
    .o_sd_controlreg (o_sd_controlreg),
    .o_sd_addr       (o_sd_addr),
    .o_sd_wdata      (o_sd_wdata),
    .i_sd_rdata      (i_sd_rdata),
    .i_sd_status     (i_sd_status),
    .i_sd_done       (i_sd_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Expected operation order from the round-robin model
  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] sector;
    logic [7:0]  wdata;
  } exp_t;

  // What the emulated controller saw, plus the behaviour it chose
  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [1:0]  gnt;
    logic [7:0]  wdata;
    int          hold;
    bit          stable;
    int          mode;      // 0 normal, 1 done during opcode hold, 2 never done
    logic [7:0]  status;
    int          rel;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_last = 1;
  int   force_mode = -1;
  bit   no_done = 1'b0;
  int   last_done = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"},   64'(o_sd_controlreg), 64'd0);
    chk({tag, "_gnt"},    64'({o_gnt1, o_gnt0}), 64'd0);
    chk({tag, "_done"},   64'({o_done1, o_done0}), 64'd0);
    chk({tag, "_err"},    64'({o_err1, o_err0}), 64'd0);
    chk({tag, "_status"}, 64'(o_status), 64'd0);
    chk({tag, "_rdata"},  64'(o_rdata), 64'd0);
    chk({tag, "_sdwd"},   64'(o_sd_wdata), 64'd0);
    chk({tag, "_addr"},   64'(o_sd_addr), 64'd0);
  endtask

  initial begin : rdata_drv
    i_sd_rdata = 8'h00;
    forever begin
      @(negedge i_clk);
      i_sd_rdata = 8'($urandom);
    end
  end

  // Emulated SD controller: watches the opcode, answers with a chosen behaviour
  initial begin : ctl_emu
    obs_t o;
    int   r;
    i_sd_done   = 1'b0;
    i_sd_status = 8'h00;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_sd_controlreg != 8'd0) begin
        o.op     = o_sd_controlreg;
        o.addr   = o_sd_addr;
        o.gnt    = {o_gnt1, o_gnt0};
        o.wdata  = o_sd_wdata;
        o.hold   = 0;
        o.stable = 1'b1;
        if (last_done >= 0)
          chk("cooldown_gap", 64'((cyc - last_done) >= int'(COOLDOWN)), 64'd1);
        r = int'($urandom_range(0, 7));
        o.mode   = (force_mode >= 0) ? force_mode : ((r == 0) ? 2 : ((r == 1) ? 1 : 0));
        o.status = 8'($urandom);
        i_sd_status = o.status;
        while (o_sd_controlreg != 8'd0 && o.hold < 200) begin
          if (o_sd_controlreg != o.op || o_sd_addr != o.addr) o.stable = 1'b0;
          o.hold++;
          if (o.mode == 1 && o.hold == 10) i_sd_done = 1'b1;
          if (o.mode == 1 && o.hold == 14) i_sd_done = 1'b0;
          @(negedge i_clk);
        end
        o.rel = cyc;
        if (!no_done) obs_q.push_back(o);
        if (o.mode == 0 && !no_done) begin
          repeat ($urandom_range(1, 40)) @(negedge i_clk);
          i_sd_done = 1'b1;
          repeat (4) @(negedge i_clk);
          i_sd_done = 1'b0;
        end
      end
    end
  end

  // Monitor: every done pulse is matched against the model and the controller view
  initial begin : monitor
    exp_t       e;
    obs_t       o;
    logic [7:0] last_ok;
    logic [1:0] port_oh;
    last_ok = 8'h00;
    forever begin
      @(negedge i_clk);
      #1;
      if (!i_rst_n) begin
        last_ok   = 8'h00;
        last_done = -1;
      end else if (o_done0 || o_done1) begin
        last_done = cyc;
        if (exp_q.size() == 0 || obs_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: actual done=%b%b required=no pulse", o_done1, o_done0);
        end else begin
          e = exp_q.pop_front();
          o = obs_q.pop_front();
          port_oh = (e.port == 1) ? 2'b10 : 2'b01;
          chk("done_port",   64'({o_done1, o_done0}), 64'(port_oh));
          chk("grant",       64'(o.gnt), 64'(port_oh));
          chk("opcode",      64'(o.op), e.wr ? 64'd2 : 64'd1);
          chk("sector",      64'(o.addr), 64'(e.sector));
          chk("op_stable",   64'(o.stable), 64'd1);
          chk("hold_cycles", 64'(o.hold), 64'(START_HOLD));
          chk("sd_wdata",    64'(o.wdata), 64'(e.wdata));
          chk("rdata_mux",   64'(o_rdata), 64'(i_sd_rdata));
          chk("err",         64'({o_err1, o_err0}), (o.mode == 2) ? 64'(port_oh) : 64'd0);
          chk("status",      64'(o_status), (o.mode == 2) ? 64'(last_ok) : 64'(o.status));
          if (o.mode != 2) last_ok = o.status;
          if (o.mode == 2)      chk("timeout_latency", 64'(cyc - o.rel), 64'(TIMEOUT));
          else if (o.mode == 1) chk("early_latency", 64'(cyc - o.rel), 64'd0);
          else                  chk("normal_latency", 64'((cyc - o.rel) < 60), 64'd1);
          @(negedge i_clk);
          #1;
          chk("gnt_released", 64'({o_gnt1, o_gnt0}), 64'd0);
          chk("wdata_idle",   64'(o_sd_wdata), 64'd0);
          chk("rdata_idle",   64'(o_rdata), 64'd0);
        end
      end
    end
  end

  task automatic do_round(input logic [1:0] mask, input int mode, input bit rnd);
    exp_t       e;
    int         first;
    int         p;
    int         budget;
    logic [1:0] pending;
    if (rnd) begin
      i_wr_nrd0 = 1'($urandom);
      i_wr_nrd1 = 1'($urandom);
      i_sector0 = $urandom;
      i_sector1 = $urandom;
      i_wdata0  = 8'($urandom);
      i_wdata1  = 8'($urandom);
    end
    first = (mask == 2'b11) ? (1 - model_last) : (mask[1] ? 1 : 0);
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : (1 - first);
      if (mask[p]) begin
        e.port   = p;
        e.wr     = (p == 1) ? i_wr_nrd1 : i_wr_nrd0;
        e.sector = (p == 1) ? i_sector1 : i_sector0;
        e.wdata  = (p == 1) ? i_wdata1 : i_wdata0;
        exp_q.push_back(e);
        model_last = p;
      end
    end
    force_mode = mode;
    i_req0  = mask[0];
    i_req1  = mask[1];
    pending = mask;
    budget  = 4000;
    while (pending != 2'b00 && budget > 0) begin
      @(negedge i_clk);
      budget--;
      if (o_done0) begin pending[0] = 1'b0; i_req0 = 1'b0; end
      if (o_done1) begin pending[1] = 1'b0; i_req1 = 1'b0; end
      // Occasionally abandon the request mid-operation; it must still complete
      if (o_gnt0 && !o_done0 && $urandom_range(0, 99) == 0) i_req0 = 1'b0;
      if (o_gnt1 && !o_done1 && $urandom_range(0, 99) == 0) i_req1 = 1'b0;
    end
    chk("round_complete", 64'(pending), 64'd0);
    i_req0 = 1'b0;
    i_req1 = 1'b0;
  endtask

  initial begin : main
    int budget;
    i_rst_n = 1'b0;
    i_req0 = 1'b0; i_req1 = 1'b0;
    i_wr_nrd0 = 1'b0; i_wr_nrd1 = 1'b0;
    i_sector0 = 32'h0; i_sector1 = 32'h0;
    i_wdata0 = 8'h5A; i_wdata1 = 8'hC3;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Contention straight after reset: 0,1 then 0,1
    i_wr_nrd0 = 1'b1; i_wr_nrd1 = 1'b1;
    i_sector0 = 32'h0000_0100; i_sector1 = 32'h0000_0200;
    do_round(2'b11, 0, 1'b0);
    i_sector0 = 32'h0000_0101; i_sector1 = 32'h0000_0201;
    do_round(2'b11, 0, 1'b0);

    // Single read of sector 0x10 on port 0
    i_wr_nrd0 = 1'b0; i_sector0 = 32'h0000_0010;
    do_round(2'b01, 0, 1'b0);

    // Timeout on port 1
    i_wr_nrd1 = 1'b0; i_sector1 = 32'h0BAD_0001;
    do_round(2'b10, 2, 1'b0);

    // Write data path on port 1
    i_wr_nrd1 = 1'b1; i_wdata1 = 8'hA5; i_wdata0 = 8'h3C; i_sector1 = 32'h0000_0042;
    do_round(2'b10, 0, 1'b0);

    // Completion strobe while the opcode is still held
    do_round(2'b01, 1, 1'b1);

    for (int n = 0; n < 20; n++) begin
      do_round(2'($urandom_range(1, 3)), -1, 1'b1);
    end

    // Reset while waiting for completion
    force_mode = 2;
    no_done    = 1'b1;
    i_wr_nrd0  = 1'b0; i_sector0 = 32'hDEAD_BEEF; i_wdata0 = 8'h77;
    i_req0     = 1'b1;
    budget     = 300;
    while (o_sd_controlreg == 8'd0 && budget > 0) begin @(negedge i_clk); budget--; end
    while (o_sd_controlreg != 8'd0 && budget > 0) begin @(negedge i_clk); budget--; end
    chk("reach_wait", 64'(budget > 0), 64'd1);
    repeat (20) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 chk_zero("rst_async");
    i_req0 = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n    = 1'b1;
    no_done    = 1'b0;
    force_mode = -1;
    model_last = 1;
    repeat (40) @(negedge i_clk);

    // Both requests together after reset: port 0 first
    do_round(2'b11, 0, 1'b1);
    repeat (30) @(negedge i_clk);
    chk("queues_drained", 64'(exp_q.size() + obs_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
